// File: rtl/ntt_cmd_sequencer_if.sv
// Host/core handshake bundle for the NTT command sequencer.
// Host command and word channels plus the core-facing opcode/data strobe.
interface ntt_cmd_sequencer_if #(
    parameter int unsigned DW    = 32,
    parameter int unsigned LENW  = 10,
    parameter int unsigned WAITW = 16
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [4:0]       cmd_op;
    logic [LENW-1:0]  cmd_len;
    logic             cmd_hold;
    logic             cmd_wdone;
    logic [WAITW-1:0] cmd_wait;
    logic             wr_valid;
    logic             wr_ready;
    logic [DW-1:0]    wr_data;
    logic [4:0]       core_op;
    logic             core_din_valid;
    logic [DW-1:0]    core_din;
    logic             core_done;
    logic             busy;
    logic             cmd_cpl;
    logic             err_timeout;

    modport master (
        output cmd_valid, cmd_op, cmd_len, cmd_hold, cmd_wdone, cmd_wait,
               wr_valid, wr_data, core_done,
        input  cmd_ready, wr_ready, core_op, core_din_valid, core_din,
               busy, cmd_cpl, err_timeout
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_len, cmd_hold, cmd_wdone, cmd_wait,
               wr_valid, wr_data, core_done,
        output cmd_ready, wr_ready, core_op, core_din_valid, core_din,
               busy, cmd_cpl, err_timeout
    );
endinterface

// File: rtl/ntt_cmd_sequencer.sv
// Cycle-exact command sequencer for the NTT1024 core: opcode pulse, gap,
// word stream, idle tail, then a counted wait or a done-edge wait with timeout.
module ntt_cmd_sequencer #(
    parameter int unsigned DW    = 32,
    parameter int unsigned LENW  = 10,
    parameter int unsigned WAITW = 16
) (
    input  logic               clk,
    input  logic               reset,
    ntt_cmd_sequencer_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ISSUE, GAP, STREAM, TAIL, WAIT} state_t;

    state_t           state, state_d;
    logic             hold_q, wdone_q;
    logic [WAITW-1:0] wait_q;
    logic [LENW-1:0]  left_q, left_d;
    logic [WAITW-1:0] wcnt_q, wcnt_d;
    logic             done_q, seen_q, seen_d;
    logic             window, take, rise, last_next, err_d, wr_ready_d;

    // True when a cycle in state s is the final cycle of the command.
    function automatic logic is_last(state_t s, logic [WAITW-1:0] w, logic seen);
        case (s)
            TAIL:    return !wdone_q && (wait_q == '0);
            WAIT:    return (wdone_q && seen) || (w <= WAITW'(1));
            default: return 1'b0;
        endcase
    endfunction

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (bus.cmd_valid && bus.cmd_ready) state_d = ISSUE;
            ISSUE:   state_d = GAP;
            GAP:     state_d = (left_q == '0) ? TAIL : STREAM;
            STREAM:  if (left_q == '0) state_d = TAIL;
            TAIL:    state_d = is_last(state, wcnt_q, seen_q) ? IDLE : WAIT;
            WAIT:    if (is_last(state, wcnt_q, seen_q)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and next output values; words are taken one cycle before they show on core_din
    always_comb begin
        window = ((state == GAP) || (state == STREAM)) && (left_q != '0);
        take   = window && (hold_q || (bus.wr_ready && bus.wr_valid));
        rise   = bus.core_done && !done_q;
        seen_d = (state != IDLE) && (seen_q || rise);
        left_d = left_q;
        wcnt_d = wcnt_q;
        if (state_d == ISSUE) begin
            left_d = bus.cmd_len;
            wcnt_d = bus.cmd_wait;
        end else begin
            if (take) left_d = left_q - LENW'(1);
            if ((state == WAIT) && (wcnt_q != '0)) wcnt_d = wcnt_q - WAITW'(1);
        end
        last_next  = is_last(state_d, wcnt_d, seen_d);
        wr_ready_d = !hold_q && ((state_d == GAP) || (state_d == STREAM)) && (left_d != '0);
        err_d      = bus.err_timeout;
        if (state_d == ISSUE) begin
            err_d = 1'b0;
        end else if (last_next && (state_d == WAIT) && wdone_q && !seen_d) begin
            err_d = 1'b1;
        end
    end

    // Latched command fields and counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_q  <= 1'b0;
            wdone_q <= 1'b0;
            wait_q  <= '0;
            left_q  <= '0;
            wcnt_q  <= '0;
            done_q  <= 1'b0;
            seen_q  <= 1'b0;
        end else begin
            if (state_d == ISSUE) begin
                hold_q  <= bus.cmd_hold;
                wdone_q <= bus.cmd_wdone;
                wait_q  <= bus.cmd_wait;
            end
            left_q <= left_d;
            wcnt_q <= wcnt_d;
            done_q <= bus.core_done;
            seen_q <= seen_d;
        end
    end

    // Registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.cmd_ready      <= 1'b0;
            bus.wr_ready       <= 1'b0;
            bus.core_op        <= '0;
            bus.core_din_valid <= 1'b0;
            bus.core_din       <= '0;
            bus.busy           <= 1'b0;
            bus.cmd_cpl        <= 1'b0;
            bus.err_timeout    <= 1'b0;
        end else begin
            bus.cmd_ready      <= (state_d == IDLE);
            bus.wr_ready       <= wr_ready_d;
            bus.core_op        <= (state_d == ISSUE) ? bus.cmd_op : 5'd0;
            bus.core_din_valid <= take;
            bus.core_din       <= (take && !hold_q) ? bus.wr_data : '0;
            bus.busy           <= (state_d != IDLE);
            bus.cmd_cpl        <= last_next;
            bus.err_timeout    <= err_d;
        end
    end
endmodule

// File: tb/tb_ntt_cmd_sequencer.sv
// Scoreboard bench for ntt_cmd_sequencer: directed commands push expected
// core events (opcode, data beat, completion) with their exact cycle.
module tb_ntt_cmd_sequencer;
    localparam int unsigned DW    = 32;
    localparam int unsigned LENW  = 10;
    localparam int unsigned WAITW = 16;
    localparam int K_OP  = 0;
    localparam int K_DAT = 1;
    localparam int K_CPL = 2;

    typedef struct {
        int          kind;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];
    logic [31:0] words [8];

    ntt_cmd_sequencer_if #(.DW(DW), .LENW(LENW), .WAITW(WAITW)) bus ();

    ntt_cmd_sequencer #(.DW(DW), .LENW(LENW), .WAITW(WAITW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic push_exp(input int kind, input logic [31:0] data, input int at);
        exp_t e;
        e.kind = kind;
        e.data = data;
        e.cyc  = at;
        sb.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic sb_check(input int kind, input logic [31:0] data);
        exp_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL sb_unexpected: got kind=%0d data=%0h cycle=%0d, want no event",
                     kind, data, cyc);
        end else begin
            e = sb.pop_front();
            if (e.kind != kind || e.data !== data || e.cyc != cyc) begin
                n_bad++;
                $display("FAIL sb_event: got kind=%0d data=%0h cycle=%0d, want kind=%0d data=%0h cycle=%0d",
                         kind, data, cyc, e.kind, e.data, e.cyc);
            end
        end
    endtask

    // Monitor: every core-facing event is popped from the scoreboard
    always @(negedge clk) begin
        if (reset) begin
            if (bus.core_op != 5'd0) sb_check(K_OP, 32'(bus.core_op));
            if (bus.core_din_valid)  sb_check(K_DAT, bus.core_din);
            if (bus.cmd_cpl)         sb_check(K_CPL, 32'(bus.err_timeout));
        end
    end

    task automatic wait_cyc(input int t);
        @(negedge clk);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic wait_drain(input int lim);
        int k = 0;
        while (sb.size() != 0 && k < lim) begin
            @(negedge clk);
            k++;
        end
        chk("sb_drain_left", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    // Offer a command; n is set so that spec cycle N+k is cyc == n+k
    task automatic send_cmd(input logic [4:0] op, input int len, input logic hold,
                            input logic wdone, input int wt, output int n);
        int guard = 0;
        @(negedge clk);
        while (!bus.cmd_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("cmd_ready_wait", 32'(bus.cmd_ready), 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_len   = LENW'(len);
        bus.cmd_hold  = hold;
        bus.cmd_wdone = wdone;
        bus.cmd_wait  = WAITW'(wt);
        @(posedge clk);
        #1;
        n = cyc - 1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 5'h1F;
        bus.cmd_len   = '1;
        bus.cmd_hold  = ~hold;
        bus.cmd_wdone = ~wdone;
        bus.cmd_wait  = '1;
    endtask

    // Drive wr_valid pattern (bit i = cycle N+2+i), then extra valid cycles that must be refused
    task automatic stream(input int n, input logic [15:0] pat, input int np, input int extra);
        int k = 0;
        for (int i = 0; i < np; i++) begin
            wait_cyc(n + 2 + i);
            bus.wr_valid = pat[i];
            bus.wr_data  = pat[i] ? words[k] : 32'hDEAD_0000 + 32'(i);
            if (pat[i]) k++;
        end
        for (int j = 0; j < extra; j++) begin
            wait_cyc(n + 2 + np + j);
            chk("wr_ready_after_last", 32'(bus.wr_ready), 32'd0);
            bus.wr_valid = 1'b1;
            bus.wr_data  = 32'hBAD0_0000 + 32'(j);
        end
        wait_cyc(n + 2 + np + extra);
        bus.wr_valid = 1'b0;
    endtask

    initial begin
        int   n;
        logic seen;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_len   = '0;
        bus.cmd_hold  = 1'b0;
        bus.cmd_wdone = 1'b0;
        bus.cmd_wait  = '0;
        bus.wr_valid  = 1'b0;
        bus.wr_data   = '0;
        bus.core_done = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_outs", 32'({bus.core_op, bus.core_din_valid, bus.wr_ready, bus.busy,
                             bus.cmd_cpl, bus.err_timeout, bus.cmd_ready}), 32'd0);
        chk("rst_din", bus.core_din, 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_ready", 32'(bus.cmd_ready), 32'd1);
        chk("idle_busy", 32'(bus.busy), 32'd0);

        // Load params: 3 words held valid
        words[0] = 32'h1; words[1] = 32'hD01; words[2] = 32'hC7F;
        send_cmd(5'b00001, 3, 1'b0, 1'b0, 0, n);
        push_exp(K_OP, 32'd1, n + 1);
        push_exp(K_DAT, 32'h1,   n + 3);
        push_exp(K_DAT, 32'hD01, n + 4);
        push_exp(K_DAT, 32'hC7F, n + 5);
        push_exp(K_CPL, 32'd0,   n + 6);
        stream(n, 16'b111, 3, 1);
        chk("t1_ready_tail", 32'(bus.cmd_ready), 32'd0);
        chk("t1_busy_tail", 32'(bus.busy), 32'd1);
        wait_cyc(n + 7);
        chk("t1_ready_after", 32'(bus.cmd_ready), 32'd1);
        wait_drain(10);

        // Stream bubbles: valid pattern 1,0,1,1,0,1
        words[0] = 32'hA1; words[1] = 32'hA2; words[2] = 32'hA3; words[3] = 32'hA4;
        send_cmd(5'b00010, 4, 1'b0, 1'b0, 0, n);
        push_exp(K_OP, 32'd2, n + 1);
        push_exp(K_DAT, 32'hA1, n + 3);
        push_exp(K_DAT, 32'hA2, n + 5);
        push_exp(K_DAT, 32'hA3, n + 6);
        push_exp(K_DAT, 32'hA4, n + 8);
        push_exp(K_CPL, 32'd0,  n + 9);
        stream(n, 16'b10_1101, 6, 2);
        wait_drain(10);

        // Hold op: 784 zero beats, no host words taken
        send_cmd(5'b01101, 784, 1'b1, 1'b0, 0, n);
        push_exp(K_OP, 32'd13, n + 1);
        for (int i = 0; i < 784; i++) push_exp(K_DAT, 32'd0, n + 3 + i);
        push_exp(K_CPL, 32'd0, n + 787);
        bus.wr_valid = 1'b1;
        bus.wr_data  = 32'hFFFF_FFFF;
        seen = 1'b0;
        for (int i = 0; i < 786; i++) begin
            wait_cyc(n + 2 + i);
            seen = seen | bus.wr_ready;
        end
        bus.wr_valid = 1'b0;
        chk("hold_wr_ready", 32'(seen), 32'd0);
        wait_drain(10);

        // Count-mode wait of 5 cycles
        send_cmd(5'b00011, 0, 1'b0, 1'b0, 5, n);
        push_exp(K_OP, 32'd3, n + 1);
        push_exp(K_CPL, 32'd0, n + 8);
        wait_drain(20);

        // Done wait: core_done rises 900 cycles after ISSUE
        send_cmd(5'b00100, 0, 1'b0, 1'b1, 2000, n);
        push_exp(K_OP, 32'd4, n + 1);
        push_exp(K_CPL, 32'd0, n + 902);
        wait_cyc(n + 901);
        bus.core_done = 1'b1;
        wait_drain(10);

        // core_done stuck high from before ISSUE: timeout after 50 WAIT cycles
        send_cmd(5'b00100, 0, 1'b0, 1'b1, 50, n);
        push_exp(K_OP, 32'd4, n + 1);
        push_exp(K_CPL, 32'd1, n + 53);
        wait_drain(70);
        bus.core_done = 1'b0;
        @(negedge clk);
        chk("err_sticky", 32'(bus.err_timeout), 32'd1);

        // Next accepted command clears the flag
        send_cmd(5'b00010, 0, 1'b0, 1'b0, 0, n);
        push_exp(K_OP, 32'd2, n + 1);
        push_exp(K_CPL, 32'd0, n + 3);
        wait_cyc(n + 1);
        chk("err_cleared", 32'(bus.err_timeout), 32'd0);
        wait_drain(10);

        // Done mode with wait=0 times out after one WAIT cycle
        send_cmd(5'b00101, 0, 1'b0, 1'b1, 0, n);
        push_exp(K_OP, 32'd5, n + 1);
        push_exp(K_CPL, 32'd1, n + 4);
        wait_drain(10);

        // Done edge during STREAM finishes on the first WAIT cycle
        send_cmd(5'b00110, 2, 1'b1, 1'b1, 100, n);
        push_exp(K_OP, 32'd6, n + 1);
        push_exp(K_DAT, 32'd0, n + 3);
        push_exp(K_DAT, 32'd0, n + 4);
        push_exp(K_CPL, 32'd0, n + 6);
        wait_cyc(n + 3);
        bus.core_done = 1'b1;
        wait_drain(10);
        bus.core_done = 1'b0;

        // Reset mid-STREAM after 10 of 128 words
        send_cmd(5'b00111, 128, 1'b0, 1'b0, 0, n);
        push_exp(K_OP, 32'd7, n + 1);
        for (int i = 0; i < 9; i++) push_exp(K_DAT, 32'h100 + 32'(i), n + 3 + i);
        for (int i = 0; i < 10; i++) begin
            wait_cyc(n + 2 + i);
            bus.wr_valid = 1'b1;
            bus.wr_data  = 32'h100 + 32'(i);
        end
        @(posedge clk);
        #3;
        bus.wr_valid = 1'b0;
        reset = 1'b0;
        #1;
        chk("abort_outs", 32'({bus.core_op, bus.core_din_valid, bus.wr_ready, bus.busy,
                               bus.cmd_cpl, bus.err_timeout, bus.cmd_ready}), 32'd0);
        chk("abort_din", bus.core_din, 32'd0);
        chk("abort_sb_left", 32'(sb.size()), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_ready", 32'(bus.cmd_ready), 32'd1);

        // Fresh command after reset
        words[0] = 32'h55; words[1] = 32'hAA;
        send_cmd(5'b01001, 2, 1'b0, 1'b0, 0, n);
        push_exp(K_OP, 32'd9, n + 1);
        push_exp(K_DAT, 32'h55, n + 3);
        push_exp(K_DAT, 32'hAA, n + 4);
        push_exp(K_CPL, 32'd0,  n + 5);
        stream(n, 16'b11, 2, 1);
        wait_drain(10);

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
